// File: rtl/wb_port_scheduler.sv
// Arbitrates the single register-file write port between pipeline writeback and buffered
// divider results, with an aging FIFO and write-after-write squashing of stale divide results.
module wb_port_scheduler #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned AGE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pipe_we,
    input  logic [4:0]               pipe_dst,
    input  logic [XLEN-1:0]          pipe_data,
    input  logic                     div_valid,
    input  logic [4:0]               div_dst,
    input  logic                     div_get_rem,
    input  logic [XLEN-1:0]          div_quotient,
    input  logic [XLEN-1:0]          div_remainder,
    output logic                     pipe_stall,
    output logic                     rf_we,
    output logic [4:0]               rf_dst,
    output logic [XLEN-1:0]          rf_data,
    output logic [31:0]              pending_mask,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam int unsigned AgeW = $clog2(AGE_LIMIT + 1);

    logic [DEPTH-1:0][4:0]      ent_dst_q,  ent_dst_d;
    logic [DEPTH-1:0][XLEN-1:0] ent_data_q, ent_data_d;
    logic [DEPTH-1:0]           ent_live_q, ent_live_d;
    logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]            count_q, count_d;
    logic [AgeW-1:0]            age_q, age_d;
    logic                       rf_we_q, rf_we_d;
    logic [4:0]                 rf_dst_q, rf_dst_d;
    logic [XLEN-1:0]            rf_data_q, rf_data_d;

    logic pipe_eff, head_valid, div_grant, pipe_grant, push;

    always_comb begin
        pipe_eff   = pipe_we && (pipe_dst != 5'd0);
        head_valid = (count_q != '0);
        div_grant  = head_valid && (!pipe_eff || (age_q >= AgeW'(AGE_LIMIT)) ||
                                    (count_q == CntW'(DEPTH)));
        pipe_grant = pipe_eff && !div_grant;
        pipe_stall = pipe_eff && div_grant;
        push       = div_valid && (div_dst != 5'd0);
    end

    always_comb begin
        ent_dst_d  = ent_dst_q;
        ent_data_d = ent_data_q;
        ent_live_d = ent_live_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        age_d      = age_q;
        rf_we_d    = 1'b0;
        rf_dst_d   = rf_dst_q;
        rf_data_d  = rf_data_q;

        if (div_grant) begin
            if (ent_live_q[rd_ptr_q]) begin
                rf_we_d   = 1'b1;
                rf_dst_d  = ent_dst_q[rd_ptr_q];
                rf_data_d = ent_data_q[rd_ptr_q];
            end
        end else if (pipe_grant) begin
            rf_we_d   = 1'b1;
            rf_dst_d  = pipe_dst;
            rf_data_d = pipe_data;
        end

        // The younger pipeline write makes older buffered results to the same register stale.
        if (pipe_grant) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_dst_q[i] == pipe_dst) ent_live_d[i] = 1'b0;
            end
        end

        if (div_grant) begin
            ent_live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d             = rd_ptr_q + PtrW'(1);
            age_d                = '0;
        end else if (head_valid && (age_q < AgeW'(AGE_LIMIT))) begin
            age_d = age_q + AgeW'(1);
        end

        // When full, the forced pop frees exactly the slot this push lands in.
        if (push) begin
            ent_dst_d[wr_ptr_q]  = div_dst;
            ent_data_d[wr_ptr_q] = div_get_rem ? div_remainder : div_quotient;
            ent_live_d[wr_ptr_q] = !(pipe_grant && (div_dst == pipe_dst));
            wr_ptr_d             = wr_ptr_q + PtrW'(1);
        end

        count_d = count_q + CntW'(push) - CntW'(div_grant);
        if (count_d == '0) age_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_dst_q  <= '0;
            ent_data_q <= '0;
            ent_live_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            age_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_dst_q   <= '0;
            rf_data_q  <= '0;
        end else begin
            ent_dst_q  <= ent_dst_d;
            ent_data_q <= ent_data_d;
            ent_live_q <= ent_live_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            age_q      <= age_d;
            rf_we_q    <= rf_we_d;
            rf_dst_q   <= rf_dst_d;
            rf_data_q  <= rf_data_d;
        end
    end

    // Free slots never hold live=1, so the mask can scan every slot.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_live_q[i]) pending_mask[ent_dst_q[i]] = 1'b1;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_dst     = rf_dst_q;
    assign rf_data    = rf_data_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed and random checks of wb_port_scheduler against a queue-based write-port model.
module tb_wb_port_scheduler;
    localparam int XLEN = 32;
    localparam int DEPTH = 2;
    localparam int AGE = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            pipe_we, div_valid, div_get_rem;
    logic [4:0]      pipe_dst, div_dst;
    logic [XLEN-1:0] pipe_data, div_quotient, div_remainder;
    logic            pipe_stall, rf_we;
    logic [4:0]      rf_dst;
    logic [XLEN-1:0] rf_data;
    logic [31:0]     pending_mask;
    logic [$clog2(DEPTH):0] fifo_count;

    wb_port_scheduler #(.XLEN(XLEN), .DEPTH(DEPTH), .AGE_LIMIT(AGE)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_we(pipe_we), .pipe_dst(pipe_dst), .pipe_data(pipe_data),
        .div_valid(div_valid), .div_dst(div_dst), .div_get_rem(div_get_rem),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .pipe_stall(pipe_stall), .rf_we(rf_we), .rf_dst(rf_dst), .rf_data(rf_data),
        .pending_mask(pending_mask), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  dst;
        logic [31:0] data;
        bit          live;
    } ent_t;

    ent_t        mq[$];
    int          mage;
    logic        e_we;
    logic [4:0]  e_dst;
    logic [31:0] e_data;
    int          tests = 0;
    int          fails = 0;
    int          stalls_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (mq[i]) if (mq[i].live) m[mq[i].dst] = 1'b1;
        return m;
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, ".rf_we"}, 64'(rf_we), 64'(e_we));
        chk({tag, ".rf_dst"}, 64'(rf_dst), 64'(e_dst));
        chk({tag, ".rf_data"}, 64'(rf_data), 64'(e_data));
        chk({tag, ".mask"}, 64'(pending_mask), 64'(model_mask()));
        chk({tag, ".count"}, 64'(fifo_count), 64'(mq.size()));
    endtask

    // One clock cycle; called just after a falling edge.
    task automatic cycle(input logic pw, input logic [4:0] pd, input logic [31:0] pdat,
                         input logic dv, input logic [4:0] dd, input logic gr,
                         input logic [31:0] qv, input logic [31:0] rv);
        bit pe, dg, pg;
        pipe_we = pw; pipe_dst = pd; pipe_data = pdat;
        div_valid = dv; div_dst = dd; div_get_rem = gr;
        div_quotient = qv; div_remainder = rv;
        #1;
        pe = pw && (pd != 0);
        dg = (mq.size() > 0) && (!pe || mage >= AGE || mq.size() == DEPTH);
        pg = pe && !dg;
        chk("pipe_stall", 64'(pipe_stall), 64'(pe && dg));
        if (pipe_stall) stalls_seen++;

        e_we = 1'b0;
        if (dg) begin
            if (mq[0].live) begin
                e_we = 1'b1; e_dst = mq[0].dst; e_data = mq[0].data;
            end
        end else if (pg) begin
            e_we = 1'b1; e_dst = pd; e_data = pdat;
        end
        if (pg) foreach (mq[i]) if (mq[i].dst == pd) mq[i].live = 1'b0;
        if (dg) begin
            void'(mq.pop_front());
            mage = 0;
        end else if (mq.size() > 0 && mage < AGE) mage++;
        if (dv && dd != 0) mq.push_back('{dd, gr ? rv : qv, !(pg && dd == pd)});
        if (mq.size() == 0) mage = 0;

        @(posedge clk); #1;
        check_regs("cyc");
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        mq.delete(); mage = 0;
        e_we = 1'b0; e_dst = '0; e_data = '0;
        check_regs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        pipe_we = 0; pipe_dst = 0; pipe_data = 0;
        div_valid = 0; div_dst = 0; div_get_rem = 0; div_quotient = 0; div_remainder = 0;
        mage = 0; stalls_seen = 0;
        @(negedge clk);
        apply_reset();

        // Idle pipe: divider result appears two cycles later.
        cycle(0, 0, 0, 1, 5, 0, 32'h7, 32'h9);
        chk("t1.mask5", 64'(pending_mask[5]), 64'd1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t1.data", 64'(rf_data), 64'h7);
        idle(2);

        // Busy pipe: the buffered result waits until it ages out, stalling exactly once.
        stalls_seen = 0;
        cycle(1, 3, 32'h100, 1, 6, 1, 32'h1, 32'h66);
        for (int i = 0; i < 8; i++) cycle(1, 3, 32'h101 + i, 0, 0, 0, 0, 0);
        chk("t2.stalls", 64'(stalls_seen), 64'd1);
        idle(2);

        // Back-to-back results while busy fill the FIFO and force a drain.
        stalls_seen = 0;
        cycle(1, 3, 32'h200, 1, 9, 0, 32'h99, 0);
        cycle(1, 3, 32'h201, 1, 10, 0, 32'hA0, 0);
        for (int i = 0; i < 6; i++) cycle(1, 3, 32'h202 + i, 0, 0, 0, 0, 0);
        chk("t3.stalls", 64'(stalls_seen >= 1), 64'd1);
        idle(3);

        // WAW: the pipeline write to x8 squashes the older divide result.
        cycle(1, 4, 32'h44, 1, 8, 0, 32'h88, 0);
        cycle(1, 8, 32'hAA, 0, 0, 0, 0, 0);
        chk("t4.mask8", 64'(pending_mask[8]), 64'd0);
        idle(4);
        chk("t4.last", 64'(rf_data), 64'hAA);

        // x0 is never written and never stalls.
        for (int i = 0; i < 3; i++) cycle(1, 0, 32'hDEAD, 1, 0, 0, 32'hBEEF, 0);
        chk("t5.count", 64'(fifo_count), 64'd0);

        // Reset with two entries queued discards them.
        cycle(1, 3, 32'h300, 1, 11, 0, 32'hB1, 0);
        cycle(1, 3, 32'h301, 1, 12, 0, 32'hC1, 0);
        chk("t6.full", 64'(fifo_count), 64'd2);
        apply_reset();
        idle(4);

        // Random traffic, small register range to provoke WAW collisions.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)), 1'($urandom),
                  $urandom, $urandom);
            if (i == 200) apply_reset();
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
